spi_prom_responder: RTL and testbench
=====================================

// Module: spi_prom_responder
// PURPOSE
//  Synthesizable SPI-flash responder emulating the M25P16 identification path, mode 0.
//  Lets the rdid master run in hardware or sim without the vendor flash model.
//  Samples SPICLK/SPIMOSI/cs_prom_n with the 50 MHz system clk.
//  Answers RDID (0x9F) with manufacturer ID, memory type and capacity bytes on SPIMISO.
// PARAMETERS
//  MAN_ID       8'h20  manufacturer ID, 1st RDID response byte
//  MEM_TYPE     8'h20  memory type, 2nd RDID response byte
//  MEM_CAP      8'h15  memory capacity, 3rd RDID response byte
//  STATUS       8'h00  status register value (RDSR, optional feature only)
//  SYNC_STAGES  2      synchronizer flops on SPICLK/SPIMOSI/cs_prom_n, >=2
// PORTS
//  clk        in   1  system clock, 50 MHz
//  reset      in   1  asynchronous, active-high reset
//  SPICLK     in   1  SPI clock from master; half-period >= 4 clk cycles
//  SPIMOSI    in   1  master-out data, sampled on SPICLK rising edge
//  cs_prom_n  in   1  chip select, active low
//  SPIMISO    out  1  responder data, updated on SPICLK falling edge
//  miso_oe    out  1  high while SPIMISO is actively driven (top level tri-states on low)
//  cmd_valid  out  1  one-clk pulse when an 8-bit opcode has been received
//  last_cmd   out  8  most recently received opcode
// BEHAVIOUR
//  Reset: SPIMISO=0, miso_oe=0, cmd_valid=0, last_cmd=8'h00, state IDLE, counters 0.
//  Inputs pass SYNC_STAGES flops; rise/fall detect on synced SPICLK.
//  Latency: edge-driven updates land SYNC_STAGES+1 clk after the SPICLK pin edge.
//  FSM states:
//   IDLE: cs high. miso_oe=0, bit_cnt=0. cs low -> CMD.
//   CMD: shift MOSI in MSB-first on each rise. On the 8th rise:
//    - latch last_cmd, pulse cmd_valid, bit_cnt=0.
//    - 0x9F -> RESP.
//    - any other opcode -> IGNORE.
//   RESP: on each fall, drive the next bit MSB-first with miso_oe=1.
//    - first fall after the opcode drives bit7 of MAN_ID.
//    - byte order: MAN_ID, MEM_TYPE, MEM_CAP.
//    - after 24 bits, drive 0x00; byte counter saturates at 3 and never wraps.
//   IGNORE: SPIMISO=0, miso_oe=0 until cs deasserts.
//  cs high (synced) in any state -> IDLE within 1 clk.
//   - Aborts mid-byte; partial opcode discarded, no cmd_valid pulse.
//  Rise and cs deassert in the same clk: deassert wins, rise ignored.
//  Async reset mid-transfer: immediate return to reset values; next cs low starts a fresh CMD.
//  Bits after the opcode in RESP/IGNORE: MOSI ignored, last_cmd not updated.
// CONFIGURATION
//  SPI_PROM_RDSR_EN defined:
//   - opcode 0x05 enters RESP with STATUS as the sole response byte.
//   - STATUS repeats every 8 bits until cs high.
//  SPI_PROM_RDSR_EN undefined: 0x05 handled as unknown -> IGNORE.
// STRUCTURE
//  Package spi_prom_pkg:
//   - CMD_RDID=8'h9F, CMD_RDSR=8'h05
//   - state typedef: IDLE/CMD/RESP/IGNORE
//   - RDID_BYTES=3
//  Sub-module spi_edge_sync:
//   - SYNC_STAGES-deep synchronizer for the 3 inputs
//   - outputs sclk_rise, sclk_fall, cs_active, mosi_s
//  Top level holds FSM, 8-bit shift-in, 8-bit shift-out, 3-bit bit_cnt, 2-bit byte_cnt.
// TESTING
//  1. rdid master, get_rdid pulse, SW=00/01/10/11 -> LED=0x15/0x20/0x20/0xFF.
//     Same expected values as with the m25p16 model.
//  2. Direct BFM sends 0x9F, then clocks 32 bits -> MISO reads 0x20,0x20,0x15,0x00.
//     cmd_valid pulses once; last_cmd=0x9F.
//  3. Opcode 0x03 -> cmd_valid pulse, last_cmd=0x03, miso_oe stays 0 for 16 further clocks.
//  4. cs high after 5 opcode bits, then full 0x9F transaction -> no pulse for the aborted opcode.
//     Second transaction returns 0x20 first.
//  5. reset asserted mid-RESP (bit 12), released, new 0x9F -> SPIMISO/miso_oe 0 during reset.
//     Fresh MAN_ID 0x20 after the new opcode.
//  6. SPI_PROM_RDSR_EN with STATUS=8'hA5, opcode 0x05, 16 bits -> 0xA5, 0xA5.
//     Without the macro -> miso_oe 0.

Source files
------------

// File: rtl/spi_prom_pkg.sv
// Shared opcodes, FSM state type and response sizing for the SPI PROM responder.
package spi_prom_pkg;

    localparam logic [7:0]  CMD_RDID   = 8'h9F;
    localparam logic [7:0]  CMD_RDSR   = 8'h05;
    localparam int unsigned RDID_BYTES = 3;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RESP,
        IGNORE
    } state_e;

endpackage

// File: rtl/spi_prom_responder_sync.sv
// Synchronizes SPICLK/SPIMOSI/cs_prom_n into the clk domain and detects SPICLK edges.
module spi_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    input  logic mosi,
    input  logic cs_n,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_active,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sclk_prev;

    // Chip select resets to the deasserted level so reset never looks like a select.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
    assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_prev;
    assign cs_active = ~cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_prom_responder.sv
// M25P16-style RDID responder (SPI mode 0), sampled with the system clock.
// Optional RDSR support is enabled by defining SPI_PROM_RDSR_EN.
module spi_prom_responder
    import spi_prom_pkg::*;
#(
    parameter logic [7:0]  MAN_ID      = 8'h20,
    parameter logic [7:0]  MEM_TYPE    = 8'h20,
    parameter logic [7:0]  MEM_CAP     = 8'h15,
    parameter logic [7:0]  STATUS      = 8'h00,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SPICLK,
    input  logic       SPIMOSI,
    input  logic       cs_prom_n,
    output logic       SPIMISO,
    output logic       miso_oe,
    output logic       cmd_valid,
    output logic [7:0] last_cmd
);

    logic sclk_rise, sclk_fall, cs_active, mosi_s;

    spi_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .sclk     (SPICLK),
        .mosi     (SPIMOSI),
        .cs_n     (cs_prom_n),
        .sclk_rise(sclk_rise),
        .sclk_fall(sclk_fall),
        .cs_active(cs_active),
        .mosi_s   (mosi_s)
    );

    state_e     state_q, state_d;
    logic [7:0] shift_in_q, shift_in_d;
    logic [7:0] shift_out_q, shift_out_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [1:0] byte_cnt_q, byte_cnt_d;
    logic       rdsr_q, rdsr_d;
    logic       miso_q, miso_d;
    logic       oe_q, oe_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [7:0] last_cmd_q, last_cmd_d;
    logic [7:0] opcode;
    logic [1:0] byte_next;

    // Byte indices past the RDID payload read as zero; RDSR always returns STATUS.
    function automatic logic [7:0] resp_byte(input logic [1:0] idx, input logic rdsr);
        if (rdsr) return STATUS;
        unique case (idx)
            2'd0:    return MAN_ID;
            2'd1:    return MEM_TYPE;
            2'd2:    return MEM_CAP;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        rdsr_d      = rdsr_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        cmd_valid_d = 1'b0;
        last_cmd_d  = last_cmd_q;
        opcode      = {shift_in_q[6:0], mosi_s};
        byte_next   = (byte_cnt_q == 2'(RDID_BYTES)) ? byte_cnt_q : byte_cnt_q + 2'd1;

        // Deselect takes priority over any SPICLK edge seen in the same cycle.
        if (!cs_active) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            rdsr_d     = 1'b0;
            miso_d     = 1'b0;
            oe_d       = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d   = CMD;
                    bit_cnt_d = '0;
                end
                CMD: begin
                    if (sclk_rise) begin
                        shift_in_d = opcode;
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            last_cmd_d  = opcode;
                            cmd_valid_d = 1'b1;
                            bit_cnt_d   = '0;
                            byte_cnt_d  = '0;
                            if (opcode == CMD_RDID) begin
                                state_d     = RESP;
                                rdsr_d      = 1'b0;
                                shift_out_d = MAN_ID;
`ifdef SPI_PROM_RDSR_EN
                            end else if (opcode == CMD_RDSR) begin
                                state_d     = RESP;
                                rdsr_d      = 1'b1;
                                shift_out_d = STATUS;
`endif
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                RESP: begin
                    if (sclk_fall) begin
                        miso_d = shift_out_q[7];
                        oe_d   = 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d   = '0;
                            byte_cnt_d  = byte_next;
                            shift_out_d = resp_byte(byte_next, rdsr_q);
                        end else begin
                            bit_cnt_d   = bit_cnt_q + 3'd1;
                            shift_out_d = {shift_out_q[6:0], 1'b0};
                        end
                    end
                end
                IGNORE: begin
                    miso_d = 1'b0;
                    oe_d   = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            rdsr_q      <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            cmd_valid_q <= 1'b0;
            last_cmd_q  <= '0;
        end else begin
            state_q     <= state_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            rdsr_q      <= rdsr_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            cmd_valid_q <= cmd_valid_d;
            last_cmd_q  <= last_cmd_d;
        end
    end

    assign SPIMISO   = miso_q;
    assign miso_oe   = oe_q;
    assign cmd_valid = cmd_valid_q;
    assign last_cmd  = last_cmd_q;

endmodule

// File: tb/tb_spi_prom_responder.sv
// Scoreboard bench for spi_prom_responder: BFM drives SPI, monitor checks opcodes and MISO bytes.
module tb_spi_prom_responder;

    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       SPICLK;
    logic       SPIMOSI;
    logic       cs_prom_n;
    logic       SPIMISO;
    logic       miso_oe;
    logic       cmd_valid;
    logic [7:0] last_cmd;

    spi_prom_responder #(
        .MAN_ID     (8'h20),
        .MEM_TYPE   (8'h20),
        .MEM_CAP    (8'h15),
        .STATUS     (8'hA5),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .SPICLK   (SPICLK),
        .SPIMOSI  (SPIMOSI),
        .cs_prom_n(cs_prom_n),
        .SPIMISO  (SPIMISO),
        .miso_oe  (miso_oe),
        .cmd_valid(cmd_valid),
        .last_cmd (last_cmd)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Byte entries are {oe seen at any bit, oe seen at every bit, data byte}.
    logic [7:0] exp_cmd[$];
    logic [9:0] exp_byte[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor state
    logic       sclk_prev = 1'b0;
    int         rise_cnt  = 0;
    int         nbits     = 0;
    logic [7:0] rx_byte   = '0;
    logic       oe_any    = 1'b0;
    logic       oe_all    = 1'b1;
    logic [7:0] e8;
    logic [9:0] e10;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset || cs_prom_n) begin
                rise_cnt = 0;
                nbits    = 0;
                oe_any   = 1'b0;
                oe_all   = 1'b1;
            end else if (SPICLK && !sclk_prev) begin
                if (rise_cnt < 8) begin
                    rise_cnt++;
                end else begin
                    rx_byte = {rx_byte[6:0], SPIMISO};
                    oe_any  = oe_any | miso_oe;
                    oe_all  = oe_all & miso_oe;
                    nbits++;
                    if (nbits == 8) begin
                        if (exp_byte.size() == 0) begin
                            check("unexpected miso byte", {22'd0, oe_any, oe_all, rx_byte}, 32'hFFFF);
                        end else begin
                            e10 = exp_byte.pop_front();
                            check("miso byte", {22'd0, oe_any, oe_all, rx_byte}, {22'd0, e10});
                        end
                        nbits  = 0;
                        oe_any = 1'b0;
                        oe_all = 1'b1;
                    end
                end
            end
            sclk_prev = SPICLK;
            if (cmd_valid) begin
                if (exp_cmd.size() == 0) begin
                    check("unexpected cmd_valid", {24'd0, last_cmd}, 32'hFFFF);
                end else begin
                    e8 = exp_cmd.pop_front();
                    check("last_cmd", {24'd0, last_cmd}, {24'd0, e8});
                end
            end
        end
    end

    task automatic wait_half();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_prom_n = 1'b0;
        wait_half();
    endtask

    task automatic cs_high();
        wait_half();
        cs_prom_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [31:0] data, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            SPIMOSI = data[i];
            wait_half();
            SPICLK = 1'b1;
            wait_half();
            SPICLK = 1'b0;
        end
    endtask

    task automatic expect_rdid();
        exp_cmd.push_back(8'h9F);
        exp_byte.push_back({2'b11, 8'h20});
        exp_byte.push_back({2'b11, 8'h20});
        exp_byte.push_back({2'b11, 8'h15});
        exp_byte.push_back({2'b11, 8'h00});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " SPIMISO"}, {31'd0, SPIMISO}, 32'd0);
        check({tag, " miso_oe"}, {31'd0, miso_oe}, 32'd0);
        check({tag, " cmd_valid"}, {31'd0, cmd_valid}, 32'd0);
        check({tag, " last_cmd"}, {24'd0, last_cmd}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        SPICLK    = 1'b0;
        SPIMOSI   = 1'b0;
        cs_prom_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // RDID with 32 response bits
        expect_rdid();
        cs_low();
        spi_bits(32'h9F, 8);
        spi_bits(32'hDEADBEEF, 32);
        cs_high();

        // Unknown opcode: no drive on MISO
        exp_cmd.push_back(8'h03);
        exp_byte.push_back({2'b00, 8'h00});
        exp_byte.push_back({2'b00, 8'h00});
        cs_low();
        spi_bits(32'h03, 8);
        spi_bits(32'hFFFF, 16);
        cs_high();

        // Aborted opcode after 5 bits, then a full RDID
        cs_low();
        spi_bits(32'h13, 5);
        cs_high();
        expect_rdid();
        cs_low();
        spi_bits(32'h9F, 8);
        spi_bits(32'h0, 32);
        cs_high();

        // Reset in the middle of the RDID response
        exp_cmd.push_back(8'h9F);
        cs_low();
        spi_bits(32'h9F, 8);
        spi_bits(32'h0, 4);
        wait_half();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("mid-resp reset");
        cs_prom_n = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        expect_rdid();
        cs_low();
        spi_bits(32'h9F, 8);
        spi_bits(32'h0, 32);
        cs_high();

        // RDSR opcode
        exp_cmd.push_back(8'h05);
`ifdef SPI_PROM_RDSR_EN
        exp_byte.push_back({2'b11, 8'hA5});
        exp_byte.push_back({2'b11, 8'hA5});
`else
        exp_byte.push_back({2'b00, 8'h00});
        exp_byte.push_back({2'b00, 8'h00});
`endif
        cs_low();
        spi_bits(32'h05, 8);
        spi_bits(32'h0, 16);
        cs_high();

        repeat (20) @(negedge clk);
        check("cmd expectations drained", exp_cmd.size(), 32'd0);
        check("byte expectations drained", exp_byte.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
